ofdm_frame_seq: RTL and testbench
=================================

Name: ofdm_frame_seq

Overview:
- Frame sequencer placed directly upstream of the channel estimator/equalizer.
- Opens one downstream bus cycle (CYC_O) per OFDM frame and passes 64-sample symbols through. The first symbol is the long preamble; NSYM data symbols follow.
- Holds CYC_O high through a drain window so the equalizer pipeline can flush, then forces a low gap so the estimator sees a fresh rising edge of CYC for the next frame.
- Reports frame completion, busy state, symbol progress and abort errors.

Parameters:
- SYM_LEN, 64, samples per OFDM symbol.
- DRAIN_CYC, 8, cycles CYC_O stays high after the last sample handshake.
- GAP_CYC, 2, cycles CYC_O is forced low between frames (must be >= 1).
- NSYM_W, 8, width of the data-symbol count.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset, asynchronous, active-low.
- DAT_I  in  32  upstream sample, Im[31:16] Re[15:0].
- WE_I  in  1  upstream write enable.
- STB_I  in  1  upstream strobe.
- CYC_I  in  1  upstream frame valid.
- ACK_O  out  1  upstream acknowledge.
- DAT_O  out  32  downstream sample.
- CYC_O  out  1  downstream cycle; one high window per frame.
- STB_O  out  1  downstream strobe.
- WE_O  out  1  downstream write enable; equals CYC_O.
- ACK_I  in  1  downstream acknowledge.
- NSYM_I  in  NSYM_W  data symbols in the next frame.
- NSYM_VLD_I  in  1  one-cycle strobe that arms a frame with NSYM_I.
- BUSY_O  out  1  high in any state other than IDLE.
- FRM_DONE_O  out  1  one-cycle pulse on GAP exit after a clean frame.
- ERR_O  out  1  sticky error flag; cleared only by reset.
- SYM_CNT_O  out  NSYM_W  index of the symbol in progress; 0 = preamble.

Behaviour:
- Reset (RST_I low, async): state IDLE; CYC_O=0; STB_O=0; FRM_DONE_O=0; ERR_O=0; SYM_CNT_O=0; all counters 0; nsym_r=0.
- States: IDLE, ARM, PRE, DATA, DRAIN, GAP.
- IDLE:
  - NSYM_VLD_I latches NSYM_I into nsym_r and moves to ARM.
  - ACK_O=0 and STB_O=0.
- ARM:
  - Wait for CYC_I=1 & WE_I=1.
  - Next cycle: CYC_O=1 and go to PRE.
- PRE and DATA (pass-through states):
  - STB_O = STB_I & WE_I & CYC_I.
  - DAT_O = DAT_I, combinational, zero added latency.
  - ACK_O = ACK_I & STB_O.
  - Handshake = STB_O & ACK_I. Each handshake increments smp_cnt.
  - smp_cnt wraps SYM_LEN-1 -> 0 on handshake.
  - On wrap in PRE: go to DATA if nsym_r != 0, else DRAIN. SYM_CNT_O increments.
  - On wrap in DATA: SYM_CNT_O increments. When SYM_CNT_O reaches nsym_r at the wrap, go to DRAIN.
- DRAIN:
  - CYC_O stays 1; STB_O=0; ACK_O=0.
  - Count DRAIN_CYC cycles, then CYC_O<=0 and go to GAP.
- GAP:
  - CYC_O=0. Count GAP_CYC cycles, then go to IDLE.
  - FRM_DONE_O pulses for 1 cycle on exit, unless the frame was aborted.
  - SYM_CNT_O clears to 0 on exit.
- Abort: CYC_I falls in PRE or DATA before the last handshake.
  - Set ERR_O.
  - Next cycle CYC_O<=0; jump straight to GAP (skip DRAIN). No FRM_DONE_O pulse.
- Re-arm while busy: NSYM_VLD_I outside IDLE is ignored and sets ERR_O.
- Re-arm on the exit cycle: NSYM_VLD_I in the same cycle as GAP exit is accepted (IDLE then ARM on the following cycle is not required; go directly to ARM).
- Downstream stall: ACK_I=0 holds smp_cnt; upstream sees ACK_O=0.
- nsym_r is frozen for the whole frame.
- Outputs DRAIN/GAP counts in exact cycles; no off-by-one slack.

Test Plan:
- Reset, NSYM_I=2 strobe, continuous STB_I/ACK_I -> CYC_O high exactly 192+DRAIN_CYC+1 cycles; 192 handshakes; FRM_DONE_O pulses once GAP_CYC cycles after CYC_O falls; SYM_CNT_O steps 0,1,2.
- NSYM_I=0 -> 64 handshakes only (preamble), then DRAIN and GAP; FRM_DONE_O=1 once; ERR_O=0.
- ACK_I low for 5 cycles at sample 30 of symbol 1 -> no sample lost or duplicated; DAT_O sequence equals the input sequence; total 192 handshakes.
- CYC_I dropped after 100 handshakes (NSYM=3) -> ERR_O=1; CYC_O low next cycle; no FRM_DONE_O; returns to IDLE after GAP_CYC.
- NSYM_VLD_I pulsed during DATA -> ERR_O=1; current frame completes with the original nsym_r.
- RST_I asserted mid-DATA -> all outputs at reset values immediately without a clock edge; new frame after release runs normally.

Source files
------------

// File: rtl/ofdm_frame_seq.sv
// OFDM frame sequencer ahead of the channel estimator: one CYC_O window per frame
// (preamble + NSYM data symbols), then a drain tail and a forced low gap.
module ofdm_frame_seq #(
  parameter int SYM_LEN   = 64,
  parameter int DRAIN_CYC = 8,
  parameter int GAP_CYC   = 2,
  parameter int NSYM_W    = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [31:0]       DAT_I,
  input  logic              WE_I,
  input  logic              STB_I,
  input  logic              CYC_I,
  output logic              ACK_O,
  output logic [31:0]       DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  input  logic [NSYM_W-1:0] NSYM_I,
  input  logic              NSYM_VLD_I,
  output logic              BUSY_O,
  output logic              FRM_DONE_O,
  output logic              ERR_O,
  output logic [NSYM_W-1:0] SYM_CNT_O
);

  localparam int SMP_W   = $clog2(SYM_LEN);
  localparam int CNT_MAX = (DRAIN_CYC > GAP_CYC) ? DRAIN_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // state | meaning
  // IDLE  | no frame armed
  // ARM   | frame armed, waiting for upstream CYC_I & WE_I
  // PRE   | passing the long preamble symbol
  // DATA  | passing data symbols 1..nsym
  // DRAIN | CYC_O held high while the equalizer flushes
  // GAP   | CYC_O forced low before the next frame
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PRE, S_DATA, S_DRAIN, S_GAP} state_t;

  state_t              state_q;
  logic                cyc_q;
  logic                done_q;
  logic                err_q;
  logic                abort_q;
  logic [SMP_W-1:0]    smp_cnt_q;
  logic [NSYM_W-1:0]   sym_cnt_q;
  logic [NSYM_W-1:0]   nsym_q;
  logic [CNT_W-1:0]    tmr_q;

  logic                pass;
  logic                stb;
  logic                hs;
  logic                wrap;
  logic                last_sym;
  logic                gap_exit;
  logic [SMP_W-1:0]    smp_cnt_d;
  logic [NSYM_W-1:0]   sym_cnt_d;

  assign pass      = (state_q == S_PRE) || (state_q == S_DATA);
  assign stb       = pass & STB_I & WE_I & CYC_I;
  assign hs        = stb & ACK_I;
  assign wrap      = hs && (smp_cnt_q == SMP_W'(SYM_LEN - 1));
  // sym_cnt_q is 0 in PRE, so this also covers the preamble-only frame
  assign last_sym  = (sym_cnt_q == nsym_q);
  assign gap_exit  = (state_q == S_GAP) && (tmr_q == '0);
  assign smp_cnt_d = wrap ? '0 : smp_cnt_q + 1'b1;
  assign sym_cnt_d = sym_cnt_q + 1'b1;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      smp_cnt_q <= '0;
      sym_cnt_q <= '0;
      nsym_q    <= '0;
      tmr_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (NSYM_VLD_I && (state_q != S_IDLE) && !gap_exit) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (NSYM_VLD_I) begin
            nsym_q  <= NSYM_I;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          if (CYC_I && WE_I) begin
            cyc_q     <= 1'b1;
            smp_cnt_q <= '0;
            sym_cnt_q <= '0;
            abort_q   <= 1'b0;
            state_q   <= S_PRE;
          end
        end
        S_PRE, S_DATA: begin
          if (!CYC_I) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            cyc_q   <= 1'b0;
            tmr_q   <= CNT_W'(GAP_CYC - 1);
            state_q <= S_GAP;
          end else if (hs) begin
            smp_cnt_q <= smp_cnt_d;
            if (wrap) begin
              // the index holds on the final symbol: it names the symbol in progress
              if (last_sym) begin
                tmr_q   <= CNT_W'(DRAIN_CYC);
                state_q <= S_DRAIN;
              end else begin
                sym_cnt_q <= sym_cnt_d;
                state_q   <= S_DATA;
              end
            end
          end
        end
        S_DRAIN: begin
          if (tmr_q == '0) begin
            cyc_q   <= 1'b0;
            tmr_q   <= CNT_W'(GAP_CYC - 1);
            state_q <= S_GAP;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_GAP: begin
          if (tmr_q == '0) begin
            sym_cnt_q <= '0;
            done_q    <= !abort_q;
            if (NSYM_VLD_I) begin
              nsym_q  <= NSYM_I;
              state_q <= S_ARM;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CYC_O      = cyc_q;
  assign WE_O       = cyc_q;
  assign STB_O      = stb;
  assign ACK_O      = hs;
  assign DAT_O      = pass ? DAT_I : '0;
  assign BUSY_O     = (state_q != S_IDLE);
  assign FRM_DONE_O = done_q;
  assign ERR_O      = err_q;
  assign SYM_CNT_O  = sym_cnt_q;

endmodule

// File: tb/tb_ofdm_frame_seq.sv
// Directed bench for ofdm_frame_seq: whole frames driven from a single process,
// DUT outputs observed on the falling edge.
module tb_ofdm_frame_seq;

  localparam int SYM_LEN   = 64;
  localparam int DRAIN_CYC = 8;
  localparam int GAP_CYC   = 2;
  localparam int NSYM_W    = 8;

  logic              CLK_I = 1'b0;
  logic              RST_I;
  logic [31:0]       DAT_I;
  logic              WE_I;
  logic              STB_I;
  logic              CYC_I;
  logic              ACK_O;
  logic [31:0]       DAT_O;
  logic              CYC_O;
  logic              STB_O;
  logic              WE_O;
  logic              ACK_I;
  logic [NSYM_W-1:0] NSYM_I;
  logic              NSYM_VLD_I;
  logic              BUSY_O;
  logic              FRM_DONE_O;
  logic              ERR_O;
  logic [NSYM_W-1:0] SYM_CNT_O;

  always #5 CLK_I = ~CLK_I;

  ofdm_frame_seq #(
    .SYM_LEN(SYM_LEN), .DRAIN_CYC(DRAIN_CYC), .GAP_CYC(GAP_CYC), .NSYM_W(NSYM_W)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I), .NSYM_I(NSYM_I), .NSYM_VLD_I(NSYM_VLD_I),
    .BUSY_O(BUSY_O), .FRM_DONE_O(FRM_DONE_O), .ERR_O(ERR_O), .SYM_CNT_O(SYM_CNT_O)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int   r_cyc_hi, r_hs, r_done, r_done_dly, r_idle_dly;
  int   r_dat_err, r_sym_err, r_ack_err, r_timeout;
  logic r_abort_cyc, r_abort_err, r_end_busy, r_end_err;
  logic [NSYM_W-1:0] r_end_sym;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int k);
    return {16'(k * 5 + 1), 16'(k ^ 16'hA000)};
  endfunction

  function automatic int exp_sym(input int hs, input int nsym);
    int s;
    s = hs / SYM_LEN;
    return (s > nsym) ? nsym : s;
  endfunction

  task automatic run_frame(input int nsym, input int stall_at, input int drop_at,
                           input int rearm_at, input bit exit_rearm, input bit skip_arm);
    int t, hs, fall_t, drop_t, stall_rem;
    bit rearmed;
    r_cyc_hi = 0; r_done = 0; r_done_dly = -1; r_idle_dly = -1;
    r_dat_err = 0; r_sym_err = 0; r_ack_err = 0; r_timeout = 0;
    r_abort_cyc = 1'bx; r_abort_err = 1'bx;
    t = 0; hs = 0; fall_t = -1; drop_t = -1; stall_rem = 5; rearmed = 0;
    if (!skip_arm) begin
      @(negedge CLK_I);
      NSYM_I = NSYM_W'(nsym); NSYM_VLD_I = 1'b1; CYC_I = 1'b0;
      @(negedge CLK_I);
      NSYM_VLD_I = 1'b0;
    end
    CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; ACK_I = 1'b1; DAT_I = pat(0);
    while (1) begin
      @(negedge CLK_I);
      t++;
      if (t > 3000) begin
        r_timeout = 1;
        break;
      end
      if ((WE_O !== CYC_O) || (ACK_O !== (ACK_I & STB_O))) r_ack_err++;
      if (CYC_O) begin
        r_cyc_hi++;
        if (int'(SYM_CNT_O) != exp_sym(hs, nsym)) r_sym_err++;
      end else if (fall_t < 0 && r_cyc_hi > 0) begin
        fall_t = t;
      end
      if (t == drop_t + 1) begin
        r_abort_cyc = CYC_O;
        r_abort_err = ERR_O;
      end
      if (FRM_DONE_O) begin
        r_done++;
        r_done_dly = t - fall_t;
      end
      if (STB_O && ACK_I) begin
        if (DAT_O !== pat(hs)) r_dat_err++;
        hs++;
      end
      NSYM_VLD_I = 1'b0;
      DAT_I = pat(hs);
      ACK_I = 1'b1;
      if (hs == stall_at && stall_rem > 0) begin
        ACK_I = 1'b0;
        stall_rem--;
      end
      if (hs == drop_at && drop_t < 0) begin
        CYC_I = 1'b0;
        drop_t = t;
      end
      if (hs == rearm_at && !rearmed) begin
        NSYM_VLD_I = 1'b1;
        NSYM_I = 8'd5;
        rearmed = 1;
      end
      if (exit_rearm && fall_t >= 0 && t == fall_t + GAP_CYC - 1) begin
        NSYM_VLD_I = 1'b1;
        NSYM_I = NSYM_W'(nsym);
      end
      if (r_done > 0 || (fall_t >= 0 && !BUSY_O)) begin
        r_idle_dly = t - fall_t;
        r_end_busy = BUSY_O;
        r_end_err  = ERR_O;
        r_end_sym  = SYM_CNT_O;
        break;
      end
    end
    r_hs = hs;
    CYC_I = 1'b0; STB_I = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int hs, input int cyc_hi,
                             input int done, input logic err);
    chk({nm, "_timeout"}, r_timeout, 0);
    chk({nm, "_hs"}, r_hs, hs);
    chk({nm, "_cyc_hi"}, r_cyc_hi, cyc_hi);
    chk({nm, "_done"}, r_done, done);
    chk({nm, "_idle_dly"}, r_idle_dly, GAP_CYC);
    chk({nm, "_dat_seq"}, r_dat_err, 0);
    chk({nm, "_sym_cnt"}, r_sym_err, 0);
    chk({nm, "_ack_we"}, r_ack_err, 0);
    chk({nm, "_err"}, 32'(r_end_err), 32'(err));
    chk({nm, "_end_sym"}, 32'(r_end_sym), 0);
    if (done > 0) chk({nm, "_done_dly"}, r_done_dly, GAP_CYC);
  endtask

  initial begin
    RST_I = 1'b0; DAT_I = '0; WE_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0;
    ACK_I = 1'b0; NSYM_I = '0; NSYM_VLD_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk("rst_cyc", 32'(CYC_O), 0);
    chk("rst_stb", 32'(STB_O), 0);
    chk("rst_busy", 32'(BUSY_O), 0);
    chk("rst_done", 32'(FRM_DONE_O), 0);
    chk("rst_err", 32'(ERR_O), 0);
    chk("rst_sym", 32'(SYM_CNT_O), 0);
    RST_I = 1'b1;

    // two data symbols, continuous flow
    run_frame(2, -1, -1, -1, 1'b0, 1'b0);
    check_frame("n2", 192, 192 + DRAIN_CYC + 1, 1, 1'b0);

    // preamble only, re-armed on the GAP exit cycle
    run_frame(0, -1, -1, -1, 1'b1, 1'b0);
    check_frame("n0", 64, 64 + DRAIN_CYC + 1, 1, 1'b0);
    chk("n0_rearm_busy", 32'(r_end_busy), 1);
    run_frame(0, -1, -1, -1, 1'b0, 1'b1);
    check_frame("n0b", 64, 64 + DRAIN_CYC + 1, 1, 1'b0);
    chk("n0b_idle", 32'(r_end_busy), 0);

    // downstream stall of 5 cycles at sample 30 of symbol 1
    run_frame(2, 64 + 30, -1, -1, 1'b0, 1'b0);
    check_frame("stall", 192, 192 + 5 + DRAIN_CYC + 1, 1, 1'b0);

    // upstream abort after 100 handshakes
    run_frame(3, -1, 100, -1, 1'b0, 1'b0);
    check_frame("abort", 100, 100, 0, 1'b1);
    chk("abort_cyc_next", 32'(r_abort_cyc), 0);
    chk("abort_err_next", 32'(r_abort_err), 1);

    // asynchronous reset in the middle of DATA
    @(negedge CLK_I);
    NSYM_I = 8'd3; NSYM_VLD_I = 1'b1;
    @(negedge CLK_I);
    NSYM_VLD_I = 1'b0; CYC_I = 1'b1; WE_I = 1'b1; STB_I = 1'b1; ACK_I = 1'b1;
    repeat (100) @(negedge CLK_I);
    chk("mid_busy", 32'(BUSY_O), 1);
    chk("mid_sym", 32'(SYM_CNT_O), 1);
    chk("mid_cyc", 32'(CYC_O), 1);
    #2 RST_I = 1'b0;
    #1;
    chk("arst_cyc", 32'(CYC_O), 0);
    chk("arst_we", 32'(WE_O), 0);
    chk("arst_stb", 32'(STB_O), 0);
    chk("arst_ack", 32'(ACK_O), 0);
    chk("arst_busy", 32'(BUSY_O), 0);
    chk("arst_sym", 32'(SYM_CNT_O), 0);
    chk("arst_err", 32'(ERR_O), 0);
    chk("arst_done", 32'(FRM_DONE_O), 0);
    @(negedge CLK_I);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b1;

    // re-arm attempt during DATA: flagged, frame keeps nsym = 2
    run_frame(2, -1, -1, 100, 1'b0, 1'b0);
    check_frame("rearm", 192, 192 + DRAIN_CYC + 1, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
